// File: rtl/romulus_round_ctrl.sv
// Round controller for a one-round-per-cycle SKINNY-128-384 datapath (Romulus).
// Drives register enable/select strobes, the round index and the 6-bit round constant.
module romulus_round_ctrl #(
  parameter int ROUNDS = 56
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       senc,
  output logic       sse,
  output logic       tk1s,
  output logic [5:0] constant,
  output logic [5:0] round,
  output logic       last,
  output logic [1:0] state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [5:0] round_q;
  logic [5:0] rc_q;
  logic       at_last;

  assign at_last = (state_q == S_ROUND) && (round_q == LAST_ROUND);

  // start and abort are plain level requests sampled every edge; there is no
  // ready: start only takes effect in IDLE or DONE and is dropped otherwise,
  // and abort always beats start and last.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = (start && !abort) ? S_LOAD : S_IDLE;
      S_LOAD:  state_d = abort ? S_IDLE : S_ROUND;
      S_ROUND: begin
        if (abort)        state_d = S_IDLE;
        else if (at_last) state_d = S_DONE;
        else              state_d = S_ROUND;
      end
      S_DONE:  state_d = (start && !abort) ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Counters are reinitialised on the way into LOAD, advance only between
  // consecutive ROUND cycles, and otherwise hold (so they never pass ROUNDS-1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_q <= 6'd0;
      rc_q    <= 6'h00;
    end else if (state_d == S_LOAD) begin
      round_q <= 6'd0;
      rc_q    <= 6'h01;
    end else if (state_q == S_ROUND && state_d == S_ROUND) begin
      round_q <= round_q + 6'd1;
      rc_q    <= {rc_q[4:0], rc_q[5] ^ rc_q[4] ^ 1'b1};
    end
  end

  assign busy     = (state_q == S_LOAD) || (state_q == S_ROUND);
  assign done     = (state_q == S_DONE);
  assign senc     = busy;
  assign sse      = (state_q == S_LOAD);
  assign tk1s     = (state_q == S_LOAD);
  assign last     = at_last;
  assign constant = rc_q;
  assign round    = round_q;
  assign state    = state_q;

endmodule
